time_param_programmer: RTL and testbench
========================================

Name: time_param_programmer

Overview:
Command-side driver for the traffic light controller's time-parameter reprogramming interface. It accepts parameter-write requests through a valid/ready port and buffers them in a small FIFO. It replays each write as a one-cycle Reprogram strobe with Time_Parameter_Selector/Time_Value held stable, keeping a minimum gap between strobes. It can also issue a "load defaults" sequence, and keeps a shadow copy of every value it has written.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
GAP_CYCLES, 2, idle cycles forced between consecutive Reprogram strobes (>=1)
DEF_P0, 4'd6, default value for selector 2'b00
DEF_P1, 4'd3, default value for selector 2'b01
DEF_P2, 4'd2, default value for selector 2'b10
DEF_P3, 4'd4, default value for selector 2'b11

Ports:
clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
wr_valid  input  1  write request present
wr_ready  output  1  FIFO can accept (= not full)
wr_sel  input  2  target parameter selector
wr_value  input  4  new time value
load_defaults  input  1  single-cycle pulse: queue write of DEF_P0..DEF_P3
busy  output  1  FIFO non-empty, sequence pending, or FSM not IDLE
wr_error  output  1  one-cycle pulse: handshaked write with wr_value==0 was dropped
Reprogram  output  1  one-cycle strobe to the controller
Time_Parameter_Selector  output  2  selector driven with strobe
Time_Value  output  4  value driven with strobe
shadow_params  output  16  last issued values, [4k+3:4k] = selector k

Behaviour:
- Reset values: Reprogram=0, Time_Parameter_Selector=0, Time_Value=0, wr_error=0, busy=0, FIFO empty, wr_ready=1 (while Reset low), shadow_params={DEF_P3,DEF_P2,DEF_P1,DEF_P0}, defaults-pending flag clear, FSM=IDLE.
- Reset mid-operation: FIFO and pending sequence are discarded. Any in-flight strobe is dropped next cycle.
- All outputs are registered.
- Accept: wr_valid&&wr_ready on an edge.
  - wr_value!=0: push {wr_sel,wr_value}.
  - wr_value==0: not pushed; wr_error=1 on the next cycle.
- wr_ready=0 when FIFO holds DEPTH entries. wr_valid while full has no effect; the requester holds the request.
- Simultaneous push and pop in the same cycle is legal and count is unchanged. When the FIFO is full, a pop frees a slot the following cycle, not combinationally.
- load_defaults sets the defaults-pending flag. A pulse while already pending or sequencing is ignored.
- FSM states:
  - IDLE: if defaults pending -> DEF (idx=0). Else if FIFO non-empty -> pop, load outputs -> STROBE. Defaults have priority over FIFO.
  - STROBE: Reprogram=1 for exactly this cycle; shadow slot[sel] updated in the same cycle -> GAP (cnt=GAP_CYCLES).
  - GAP: Reprogram=0, Selector/Value held; decrement cnt; at cnt reaching 0 -> return to DEF (if idx<4) or IDLE.
  - DEF: load selector=idx, value=DEF_Pidx, idx++ -> STROBE. After idx 3's GAP, clear the pending flag -> IDLE.
- Latency: write accepted at edge N into an empty FIFO with FSM in IDLE -> Reprogram high during cycle N+2 (pop cycle N+1).
- Throughput: at most one strobe per GAP_CYCLES+2 cycles.
- Time_Parameter_Selector/Time_Value change only on the cycle entering STROBE. They are stable for the whole strobe and the gap that follows.
- A defaults request arriving while a FIFO write is in STROBE/GAP waits until that write's GAP completes. Queued FIFO entries are issued after all four defaults.
- Writes are still accepted during the defaults sequence.
- Shadow width: 4 bits per slot, no saturation or arithmetic. The value is stored verbatim.

Test Plan:
- Reset held 5 cycles then released -> Reprogram=0, shadow_params=16'h4236, wr_ready=1, busy=0.
- Single write sel=2'b11 value=4 into idle block -> Reprogram pulses 1 cycle exactly 2 cycles after handshake with Selector=11, Value=4. shadow_params[15:12]=4. busy drops after GAP_CYCLES.
- Burst of 5 writes back-to-back, DEPTH=4 -> wr_ready low after 4th accept; 5th accepted once first entry popped. 5 strobes in order with >=GAP_CYCLES idle cycles between them.
- Write sel=2'b01 value=0 -> wr_error pulse 1 cycle, no strobe, FIFO count unchanged.
- load_defaults same cycle as write (sel=01, val=8) -> strobes in order 00/6, 01/3, 10/2, 11/4, then 01/8. Final shadow_params[7:4]=8.
- Reset asserted during GAP with 3 entries queued -> no further strobes. Outputs and shadow return to reset values the next cycle.

Source files
------------

// File: rtl/time_param_programmer.sv
// Command-side driver for the traffic light controller's time-parameter port:
// buffers parameter writes, replays them as spaced Reprogram strobes, and can load defaults.
module time_param_programmer #(
  parameter int         DEPTH      = 4,
  parameter int         GAP_CYCLES = 2,
  parameter logic [3:0] DEF_P0     = 4'd6,
  parameter logic [3:0] DEF_P1     = 4'd3,
  parameter logic [3:0] DEF_P2     = 4'd2,
  parameter logic [3:0] DEF_P3     = 4'd4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_sel,
  input  logic [3:0]  wr_value,
  input  logic        load_defaults,
  output logic        busy,
  output logic        wr_error,
  output logic        Reprogram,
  output logic [1:0]  Time_Parameter_Selector,
  output logic [3:0]  Time_Value,
  output logic [15:0] shadow_params
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES);
  localparam logic [15:0]      SHADOW_RST = {DEF_P3, DEF_P2, DEF_P1, DEF_P0};

  typedef enum logic [1:0] {ST_IDLE, ST_DEF, ST_STROBE, ST_GAP} state_t;

  logic [5:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_n;
  state_t           state, state_n;
  logic [2:0]       idx, idx_n;
  logic [GAP_W-1:0] cnt, cnt_n;
  logic             pending, pending_n, clear_pending;
  logic             def_active, def_active_n;
  logic             accept, push, pop, load;
  logic [1:0]       load_sel;
  logic [3:0]       load_val;

  function automatic logic [3:0] def_value(input logic [1:0] sel);
    unique case (sel)
      2'd0:    return DEF_P0;
      2'd1:    return DEF_P1;
      2'd2:    return DEF_P2;
      default: return DEF_P3;
    endcase
  endfunction

  // Zero is not a legal time value: such writes are handshaked but dropped.
  assign accept = wr_valid && wr_ready;
  assign push   = accept && (wr_value != 4'd0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_n       = state;
    idx_n         = idx;
    cnt_n         = cnt;
    def_active_n  = def_active;
    clear_pending = 1'b0;
    pop           = 1'b0;
    load          = 1'b0;
    load_sel      = Time_Parameter_Selector;
    load_val      = Time_Value;
    unique case (state)
      ST_IDLE: begin
        if (pending) begin
          state_n      = ST_DEF;
          idx_n        = 3'd0;
          def_active_n = 1'b1;
        end else if (count != '0) begin
          pop                = 1'b1;
          load               = 1'b1;
          {load_sel, load_val} = mem[rd_ptr];
          state_n            = ST_STROBE;
        end
      end
      ST_DEF: begin
        load     = 1'b1;
        load_sel = idx[1:0];
        load_val = def_value(idx[1:0]);
        idx_n    = idx + 3'd1;
        state_n  = ST_STROBE;
      end
      ST_STROBE: begin
        cnt_n   = GAP_LOAD;
        state_n = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == GAP_W'(1)) begin
          if (def_active && idx != 3'd4) begin
            state_n = ST_DEF;
          end else begin
            clear_pending = def_active;
            def_active_n  = 1'b0;
            state_n       = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - GAP_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A defaults request while one is pending or running is ignored.
    pending_n = pending ? !clear_pending : load_defaults;
    count_n   = count + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_sel, wr_value};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state                   <= ST_IDLE;
      idx                     <= 3'd0;
      cnt                     <= '0;
      pending                 <= 1'b0;
      def_active              <= 1'b0;
      rd_ptr                  <= '0;
      wr_ptr                  <= '0;
      count                   <= '0;
      wr_ready                <= 1'b1;
      busy                    <= 1'b0;
      wr_error                <= 1'b0;
      Reprogram               <= 1'b0;
      Time_Parameter_Selector <= 2'd0;
      Time_Value              <= 4'd0;
      shadow_params           <= SHADOW_RST;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      pending    <= pending_n;
      def_active <= def_active_n;
      count      <= count_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // Status outputs are registered from next-state values so they match the new state.
      wr_ready  <= (count_n != FULL);
      busy      <= (count_n != '0) || pending_n || (state_n != ST_IDLE);
      wr_error  <= accept && (wr_value == 4'd0);
      Reprogram <= (state_n == ST_STROBE);
      if (load) begin
        Time_Parameter_Selector            <= load_sel;
        Time_Value                         <= load_val;
        shadow_params[{load_sel, 2'b00} +: 4] <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_time_param_programmer.sv
// Scoreboard bench for time_param_programmer: stimulus pushes expected strobes,
// a monitor pops and compares them whenever Reprogram is seen.
module tb_time_param_programmer;

  localparam int GAP = 2;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] val;
  } strobe_t;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [1:0]  wr_sel = 2'd0;
  logic [3:0]  wr_value = 4'd0;
  logic        load_defaults = 1'b0;
  logic        busy, wr_error, Reprogram;
  logic [1:0]  Time_Parameter_Selector;
  logic [3:0]  Time_Value;
  logic [15:0] shadow_params;

  time_param_programmer dut (
    .clk                     (clk),
    .Reset                   (Reset),
    .wr_valid                (wr_valid),
    .wr_ready                (wr_ready),
    .wr_sel                  (wr_sel),
    .wr_value                (wr_value),
    .load_defaults           (load_defaults),
    .busy                    (busy),
    .wr_error                (wr_error),
    .Reprogram               (Reprogram),
    .Time_Parameter_Selector (Time_Parameter_Selector),
    .Time_Value              (Time_Value),
    .shadow_params           (shadow_params)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int      checks = 0;
  int      failures = 0;
  int      strobe_cnt = 0;
  int      last_strobe_cyc = 0;
  logic    have_last = 1'b0;
  strobe_t last_sv;
  strobe_t mon_e;
  strobe_t exp_q[$];
  logic [3:0] model_shadow [4];
  int      hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] model_word();
    return {model_shadow[3], model_shadow[2], model_shadow[1], model_shadow[0]};
  endfunction

  task automatic reset_model();
    model_shadow[0] = 4'd6;
    model_shadow[1] = 4'd3;
    model_shadow[2] = 4'd2;
    model_shadow[3] = 4'd4;
  endtask

  task automatic push_defaults();
    exp_q.push_back(strobe_t'({2'd0, 4'd6}));
    exp_q.push_back(strobe_t'({2'd1, 4'd3}));
    exp_q.push_back(strobe_t'({2'd2, 4'd2}));
    exp_q.push_back(strobe_t'({2'd3, 4'd4}));
  endtask

  // Monitor: samples one time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (Reset) begin
        have_last = 1'b0;
      end else if (Reprogram) begin
        if (have_last)
          check("strobe_spacing", 32'((cyc - last_strobe_cyc) >= GAP + 2), 32'd1);
        if (exp_q.size() == 0) begin
          fail("unexpected_strobe");
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_sel_val", 32'({Time_Parameter_Selector, Time_Value}), 32'(mon_e));
          model_shadow[mon_e.sel] = mon_e.val;
          check("shadow_at_strobe", 32'(shadow_params), 32'(model_word()));
        end
        strobe_cnt++;
        last_strobe_cyc = cyc;
        last_sv = {Time_Parameter_Selector, Time_Value};
        have_last = 1'b1;
      end else if (have_last && (cyc - last_strobe_cyc) <= GAP) begin
        check("held_during_gap", 32'({Time_Parameter_Selector, Time_Value}), 32'(last_sv));
      end
    end
  end

  // Issue one write; with_def also pulses load_defaults on the same edge.
  task automatic send(input logic [1:0] s, input logic [3:0] v, input logic with_def,
                      output int hs_cyc);
    int waited = 0;
    wr_valid = 1'b1;
    wr_sel   = s;
    wr_value = v;
    while (!wr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!wr_ready) begin
      fail("send_timeout");
      wr_valid = 1'b0;
      hs_cyc = -1;
      return;
    end
    load_defaults = with_def;
    if (with_def) push_defaults();
    if (v != 4'd0) exp_q.push_back(strobe_t'({s, v}));
    @(negedge clk);
    hs_cyc = cyc;
    wr_valid = 1'b0;
    load_defaults = 1'b0;
    check("wr_error_pulse", 32'(wr_error), 32'(v == 4'd0));
  endtask

  task automatic pulse_defaults(input logic expect_new);
    load_defaults = 1'b1;
    if (expect_new) push_defaults();
    @(negedge clk);
    load_defaults = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (strobe_cnt < target) fail("strobe_wait_timeout");
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) fail("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int b;
    reset_model();

    // Reset held five cycles, then released.
    repeat (5) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("reset_reprogram", 32'(Reprogram), 32'd0);
    check("reset_shadow", 32'(shadow_params), 32'h4236);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sel_val", 32'({Time_Parameter_Selector, Time_Value}), 32'd0);

    // Single write into an idle block: strobe lands in the cycle ending two edges after the handshake.
    base = strobe_cnt;
    send(2'd3, 4'd4, 1'b0, hs);
    wait_strobes(base + 1, 20);
    check("single_latency", 32'(last_strobe_cyc - hs), 32'd1);
    check("single_shadow_slot3", 32'(shadow_params[15:12]), 32'd4);
    b = 0;
    repeat (GAP + 3) begin
      @(negedge clk);
      if (busy) b++;
    end
    check("busy_cycles_after_strobe", 32'(b), 32'(GAP));

    // Zero-valued write: error pulse, no strobe, nothing queued.
    base = strobe_cnt;
    send(2'd1, 4'd0, 1'b0, hs);
    @(negedge clk);
    check("wr_error_one_cycle", 32'(wr_error), 32'd0);
    repeat (6) @(negedge clk);
    check("zero_write_no_strobe", 32'(strobe_cnt), 32'(base));
    check("zero_write_not_busy", 32'(busy), 32'd0);

    // Defaults and a write on the same edge: defaults go first.
    send(2'd1, 4'd8, 1'b1, hs);
    wait_drain(200);
    check("defaults_then_write_slot1", 32'(shadow_params[7:4]), 32'd8);
    check("defaults_then_write_shadow", 32'(shadow_params), 32'h4286);

    // Burst of five writes while a defaults sequence keeps the FIFO from draining.
    pulse_defaults(1'b1);
    repeat (3) @(negedge clk);
    pulse_defaults(1'b0);
    for (int i = 0; i < 5; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 1'b0, hs);
      if (i == 3) check("full_after_4th", 32'(wr_ready), 32'd0);
    end
    wait_drain(300);

    // Defaults requested while a FIFO write is strobing: that write's gap completes first.
    base = strobe_cnt;
    send(2'd2, 4'd9, 1'b0, hs);
    wait_strobes(base + 1, 20);
    send(2'd0, 4'd5, 1'b1, hs);
    send(2'd3, 4'd7, 1'b0, hs);
    wait_drain(300);
    check("defaults_mid_gap_shadow", 32'(shadow_params), 32'h7235);

    // Randomized traffic, zero values included.
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0, hs);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain(2000);
    check("random_final_shadow", 32'(shadow_params), 32'(model_word()));

    // Reset during a gap with three entries still queued.
    base = strobe_cnt;
    for (int i = 0; i < 4; i++) send(2'(i), 4'(i + 10), 1'b0, hs);
    check("one_strobe_before_reset", 32'(strobe_cnt), 32'(base + 1));
    check("in_gap_before_reset", 32'(Reprogram), 32'd0);
    Reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset_model();
    check("midreset_reprogram", 32'(Reprogram), 32'd0);
    check("midreset_sel_val", 32'({Time_Parameter_Selector, Time_Value}), 32'd0);
    check("midreset_shadow", 32'(shadow_params), 32'h4236);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_wr_ready", 32'(wr_ready), 32'd1);
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_strobe_after_reset", 32'(strobe_cnt), 32'(base + 1));
    check("idle_after_reset", 32'(busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
